// File: rtl/opstack.sv
// opstack: operand stack with pop-before-push semantics and a sticky trap.
// Up to two entries pop and one entry pushes per cycle. All outputs are
// registers updated one cycle after the request. Any trap (underflow,
// overflow, type mismatch) freezes the stack until reset.
// Optional feature macro: OPSTACK_TYPECHECK_EN.
//   When defined, a 2-bit type tag is stored with every entry.
//   Each popped tag is checked against pop_type.
module opstack #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic [1:0]       push_type,
    input  logic [1:0]       pop,
    input  logic [1:0]       pop_type,
    output logic [WIDTH-1:0] top0,
    output logic [WIDTH-1:0] top1,
    output logic             empty,
    output logic [DEPTH:0]   size,
    output logic [3:0]       trap
);

    localparam int              CAP        = 2 ** DEPTH;
    localparam logic [DEPTH+1:0] CAP_W     = (DEPTH + 2)'(CAP);
    localparam logic [3:0]      TRAP_NONE  = 4'd0;
    localparam logic [3:0]      TRAP_OVER  = 4'd1;
    localparam logic [3:0]      TRAP_UNDER = 4'd2;
    localparam logic [3:0]      TRAP_TYPE  = 4'd3;

    // Storage and architectural state
    logic [WIDTH-1:0] mem_r [CAP];
    logic [DEPTH:0]   size_r;
    logic [3:0]       trap_r;
    logic [WIDTH-1:0] top0_r;
    logic [WIDTH-1:0] top1_r;
    logic             empty_r;

    // Request decode and next-state values
    logic [DEPTH:0]   pop_cnt_s;
    logic [DEPTH:0]   base_s;
    logic [DEPTH+1:0] new_size_s;
    logic             underflow_s;
    logic             overflow_s;
    logic             mismatch_s;
    logic             accept_s;
    logic [3:0]       trap_next_s;
    logic [DEPTH-1:0] wr_idx_s;
    logic [DEPTH-1:0] rd1_idx_s;
    logic [DEPTH-1:0] rd2_idx_s;
    logic [WIDTH-1:0] top0_next_s;
    logic [WIDTH-1:0] top1_next_s;

    // Normalise the pop request: 3 behaves as 2.
    always_comb begin
        pop_cnt_s = '0;
        case (pop)
            2'd0:    pop_cnt_s = (DEPTH + 1)'(0);
            2'd1:    pop_cnt_s = (DEPTH + 1)'(1);
            2'd2:    pop_cnt_s = (DEPTH + 1)'(2);
            default: pop_cnt_s = (DEPTH + 1)'(2);
        endcase
    end

    // Size arithmetic and the underflow / overflow checks.
    // base_s is only meaningful when there is no underflow.
    always_comb begin
        base_s      = size_r - pop_cnt_s;
        new_size_s  = {1'b0, base_s} + {{(DEPTH + 1){1'b0}}, push};
        underflow_s = (pop_cnt_s > size_r);
        overflow_s  = (new_size_s > CAP_W);
        wr_idx_s    = base_s[DEPTH-1:0];
        rd1_idx_s   = base_s[DEPTH-1:0] - DEPTH'(1);
        rd2_idx_s   = base_s[DEPTH-1:0] - DEPTH'(2);
    end

`ifdef OPSTACK_TYPECHECK_EN
    logic [1:0]       tag_r [CAP];
    logic [DEPTH-1:0] tidx0_s;
    logic [DEPTH-1:0] tidx1_s;

    // Compare the tags of every entry being popped against pop_type.
    always_comb begin
        tidx0_s    = size_r[DEPTH-1:0] - DEPTH'(1);
        tidx1_s    = size_r[DEPTH-1:0] - DEPTH'(2);
        mismatch_s = 1'b0;
        if ((pop_cnt_s >= (DEPTH + 1)'(1)) && (tag_r[tidx0_s] != pop_type)) begin
            mismatch_s = 1'b1;
        end else if ((pop_cnt_s >= (DEPTH + 1)'(2)) && (tag_r[tidx1_s] != pop_type)) begin
            mismatch_s = 1'b1;
        end else begin
            mismatch_s = 1'b0;
        end
    end

    // Tag storage follows the data storage write.
    always_ff @(posedge clk) begin
        if (!reset && accept_s && push) begin
            tag_r[wr_idx_s] <= push_type;
        end
    end
`else
    logic unused_type_s;

    // Without type checking the tag inputs have no effect.
    always_comb begin
        mismatch_s    = 1'b0;
        unused_type_s = ^{push_type, pop_type};
    end
`endif

    // Trap selection by priority: underflow, then type, then overflow.
    always_comb begin
        trap_next_s = TRAP_NONE;
        accept_s    = 1'b0;
        if (trap_r != TRAP_NONE) begin
            trap_next_s = trap_r;
            accept_s    = 1'b0;
        end else if (underflow_s) begin
            trap_next_s = TRAP_UNDER;
            accept_s    = 1'b0;
        end else if (mismatch_s) begin
            trap_next_s = TRAP_TYPE;
            accept_s    = 1'b0;
        end else if (overflow_s) begin
            trap_next_s = TRAP_OVER;
            accept_s    = 1'b0;
        end else begin
            trap_next_s = TRAP_NONE;
            accept_s    = 1'b1;
        end
    end

    // Next visible top entries.
    // Reads use pre-write storage, which is valid because the write lands
    // at index base_s, above every entry read here.
    always_comb begin
        top0_next_s = '0;
        top1_next_s = '0;
        if (push) begin
            top0_next_s = push_data;
            if (base_s >= (DEPTH + 1)'(1)) begin
                top1_next_s = mem_r[rd1_idx_s];
            end else begin
                top1_next_s = '0;
            end
        end else begin
            if (base_s >= (DEPTH + 1)'(1)) begin
                top0_next_s = mem_r[rd1_idx_s];
            end else begin
                top0_next_s = '0;
            end
            if (base_s >= (DEPTH + 1)'(2)) begin
                top1_next_s = mem_r[rd2_idx_s];
            end else begin
                top1_next_s = '0;
            end
        end
    end

    // Size, trap and registered top/empty outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            size_r  <= '0;
            trap_r  <= TRAP_NONE;
            top0_r  <= '0;
            top1_r  <= '0;
            empty_r <= 1'b1;
        end else if (trap_r == TRAP_NONE) begin
            if (accept_s) begin
                size_r  <= new_size_s[DEPTH:0];
                top0_r  <= top0_next_s;
                top1_r  <= top1_next_s;
                empty_r <= (new_size_s == '0);
            end else begin
                trap_r  <= trap_next_s;
            end
        end
    end

    // Data storage is not reset; only size decides which entries are live.
    always_ff @(posedge clk) begin
        if (!reset && accept_s && push) begin
            mem_r[wr_idx_s] <= push_data;
        end
    end

    assign top0  = top0_r;
    assign top1  = top1_r;
    assign empty = empty_r;
    assign size  = size_r;
    assign trap  = trap_r;

endmodule

// File: tb/tb_opstack.sv
// Scoreboard bench for opstack.
// Runs directed scenarios, then randomized traffic, against a queue-based
// stack model.
module tb_opstack;

    localparam int W   = 64;
    localparam int D   = 2;
    localparam int CAP = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          push = 1'b0;
    logic [W-1:0]  push_data = '0;
    logic [1:0]    push_type = 2'd0;
    logic [1:0]    pop = 2'd0;
    logic [1:0]    pop_type = 2'd0;
    logic [W-1:0]  top0;
    logic [W-1:0]  top1;
    logic          empty;
    logic [D:0]    size;
    logic [3:0]    trap;

    opstack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data),
        .push_type(push_type), .pop(pop), .pop_type(pop_type),
        .top0(top0), .top1(top1), .empty(empty), .size(size), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] t0;
        logic [W-1:0] t1;
        int           sz;
        logic         em;
        int           tr;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] md[$];
    logic [1:0]   mt[$];
    int           mtrap = 0;
    int           n_cmp = 0;
    int           n_bad = 0;

`ifdef OPSTACK_TYPECHECK_EN
    localparam bit TC = 1'b1;
`else
    localparam bit TC = 1'b0;
`endif

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every response cycle is checked against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("size",  W'(size),  W'(e.sz));
            chk("empty", W'(empty), W'(e.em));
            chk("trap",  W'(trap),  W'(e.tr));
            chk("top0",  top0,      e.t0);
            chk("top1",  top1,      e.t1);
        end
    end

    // One request cycle: drive inputs, advance the model, queue expectation.
    task automatic step(input bit rs, input bit ps, input logic [W-1:0] d,
                        input logic [1:0] pt, input logic [1:0] pp, input logic [1:0] popt);
        exp_t e;
        int   pe;
        bit   bad;
        @(negedge clk);
        reset = rs; push = ps; push_data = d; push_type = pt; pop = pp; pop_type = popt;
        pe = (pp == 2'd3) ? 2 : int'(pp);
        if (rs) begin
            md.delete(); mt.delete(); mtrap = 0;
        end else if (mtrap == 0) begin
            bad = 1'b0;
            if (TC && pe <= md.size()) begin
                for (int i = 0; i < pe; i++) begin
                    if (mt[mt.size() - 1 - i] != popt) bad = 1'b1;
                end
            end
            if (pe > md.size()) mtrap = 2;
            else if (bad) mtrap = 3;
            else if (md.size() - pe + int'(ps) > CAP) mtrap = 1;
            else begin
                for (int i = 0; i < pe; i++) begin
                    void'(md.pop_back()); void'(mt.pop_back());
                end
                if (ps) begin
                    md.push_back(d); mt.push_back(pt);
                end
            end
        end
        e.sz = md.size();
        e.em = (md.size() == 0);
        e.tr = mtrap;
        e.t0 = (md.size() >= 1) ? md[md.size() - 1] : '0;
        e.t1 = (md.size() >= 2) ? md[md.size() - 2] : '0;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, 2'd0, 2'd0, 2'd0);
    endtask

    task automatic do_push(input logic [W-1:0] d, input logic [1:0] t);
        step(1'b0, 1'b1, d, t, 2'd0, 2'd0);
    endtask

    initial begin
        logic [1:0]   pp;
        logic [1:0]   pty;
        logic [1:0]   ptt;
        bit           ps;
        bit           rs;
        logic [W-1:0] dd;

        do_reset();
        // push 5 onto an empty stack
        do_push(64'h5, 2'd0);
        // replace top: push 0 then pop 1 / push 1
        do_reset();
        do_push(64'h0, 2'd0);
        step(1'b0, 1'b1, 64'h1, 2'd0, 2'd1, 2'd0);
        // binary operator: push 3, 4 then pop 2 / push 7
        do_reset();
        do_push(64'h3, 2'd0);
        do_push(64'h4, 2'd0);
        step(1'b0, 1'b1, 64'h7, 2'd0, 2'd2, 2'd0);
        // underflow, ignored push, then reset clears the trap
        do_reset();
        step(1'b0, 1'b0, '0, 2'd0, 2'd1, 2'd0);
        do_push(64'h9, 2'd0);
        do_reset();
        // overflow on a full stack
        for (int i = 0; i < CAP; i++) do_push(W'(i + 10), 2'd0);
        do_push(64'hAA, 2'd0);
        step(1'b0, 1'b0, '0, 2'd0, 2'd1, 2'd0);
        // pop 1 / push 1 on a full stack is legal
        do_reset();
        for (int i = 0; i < CAP; i++) do_push(W'(i + 20), 2'd0);
        step(1'b0, 1'b1, 64'hBB, 2'd0, 2'd1, 2'd0);
        // pop 3 acts as pop 2
        step(1'b0, 1'b0, '0, 2'd0, 2'd3, 2'd0);
        // type tag mismatch (traps only when type checking is built)
        do_reset();
        do_push(64'h11, 2'd1);
        step(1'b0, 1'b0, '0, 2'd0, 2'd1, 2'd0);
        do_reset();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rs  = ($urandom_range(0, 99) < 2) || (mtrap != 0 && $urandom_range(0, 3) == 0);
            ps  = $urandom_range(0, 1);
            pp  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) pp = 2'd0;
            dd  = {$urandom, $urandom};
            ptt = 2'($urandom_range(0, 3));
            if (mt.size() > 0 && $urandom_range(0, 9) < 9) pty = mt[mt.size() - 1];
            else pty = 2'($urandom_range(0, 3));
            step(rs, ps, dd, ptt, pp, pty);
        end

        @(negedge clk);
        reset = 1'b0; push = 1'b0; pop = 2'd0;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/opstack.md
OPSTACK -- requirements
Module: opstack

Interface
REQ-001 Parameter WIDTH, default 64, data width of one stack entry in bits.
REQ-002 Parameter DEPTH, default 4, log2 of entry count (capacity 2**DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 push  input  1  push push_data this cycle.
REQ-006 push_data  input  WIDTH  value to push.
REQ-007 push_type  input  2  type tag of pushed value (0 i32, 1 i64, 2 f32, 3 f64); used only with OPSTACK_TYPECHECK_EN.
REQ-008 pop  input  2  entries to pop this cycle (0, 1, 2; 3 is treated as 2).
REQ-009 pop_type  input  2  type tag that each popped entry must have; used only with OPSTACK_TYPECHECK_EN.
REQ-010 top0  output  WIDTH  current top entry; 0 when empty.
REQ-011 top1  output  WIDTH  entry below top; 0 when fewer than 2 entries.
REQ-012 empty  output  1  high when the stack holds 0 entries.
REQ-013 size  output  DEPTH+1  current entry count.
REQ-014 trap  output  4  sticky trap code (0 none, 1 overflow, 2 underflow, 3 type mismatch).

Function
REQ-015 Pops are applied before the push in the same cycle, so pop=1 with push=1 replaces the top and size is unchanged.
REQ-016 New size equals size - pop + push; all outputs reflect it on the cycle after the edge (one-cycle latency).
REQ-017 top0 and top1 are driven from registered state only, with no combinational path from push_data or pop.
REQ-018 Underflow: pop greater than size sets trap=2, and the stack state is left unchanged.
REQ-019 Overflow: size - pop + push greater than 2**DEPTH sets trap=1, and the stack state is left unchanged.
REQ-020 Push into a full stack with pop>=1 in the same cycle is legal and does not overflow.
REQ-021 While trap is nonzero, all push and pop requests are ignored and state is frozen until reset.
REQ-022 If several trap conditions occur in one cycle, priority is underflow, then type mismatch, then overflow.
REQ-023 pop=2 with push=1 pops two entries and pushes one, for binary operators such as i32.add.
REQ-024 Storage is a register array indexed by size; the storage index never wraps; out-of-range accesses are prevented by REQ-018/019.

Reset
REQ-025 On reset: size=0, empty=1, top0=0, top1=0, trap=0.
REQ-026 Reset overrides any simultaneous push or pop, and also clears a trap.
REQ-027 Stored data need not be cleared by reset; only the size and trap registers are reset.

Configuration
REQ-028 With macro OPSTACK_TYPECHECK_EN defined:
- each entry stores a 2-bit type tag alongside its data;
- every popped entry whose tag differs from pop_type sets trap=3, and the stack state is left unchanged.
REQ-029 Without OPSTACK_TYPECHECK_EN:
- no tag storage is built;
- push_type and pop_type are ignored;
- trap=3 is never produced.

Verification
REQ-030 Reset, then push 0x5 -> next cycle size=1, top0=0x5, empty=0, trap=0.
REQ-031 Push 0x0, then pop=1 with push=1 and push_data=1 (i32.eqz) -> size=1, top0=1, empty=0.
REQ-032 Push 3, push 4, then pop=2 with push=1 and push_data=7 -> size=1, top0=7, top1=0.
REQ-033 From empty, pop=1 -> trap=2, size=0; a later push is ignored; a reset pulse returns trap to 0.
REQ-034 DEPTH=2: push 4 values, then push again -> trap=1, size=4; in a separate run, pop=1 with push=1 when full -> no trap.
REQ-035 With OPSTACK_TYPECHECK_EN: push with type 1, then pop=1 with pop_type=0 -> trap=3, size=1; without the macro -> size=0, trap=0.
